// File: rtl/mem_access_ctrl.sv
// Purpose: MEM-stage controller. Issues one data-memory request per memory op and returns a one-cycle result to MEM/WB. Optional build macro: MEM_ACCESS_TIMEOUT_EN (bounded WAIT with err_timeout).
// Latency: non-memory op 1 cycle; memory op 2 cycles minimum (REQ then RESP), plus one cycle per WAIT; misaligned op 1 cycle.
// Backpressure: stall holds upstream from the accept cycle through the last WAIT cycle; the memory paces completion through mem_done.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] aluOutput_in,
    input  logic [15:0] B_in,
    input  logic        DMemEn_in,
    input  logic        DMemWrite_in,
    input  logic        DMemDump_in,
    input  logic        MemToReg_in,
    input  logic        RegWrite_in,
    input  logic [2:0]  WriteRegister_in,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_dump,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_reg,
    output logic        wb_regwrite,
    output logic        err_align,
    output logic        err_timeout,
    output logic        halted
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        mem_dump_q, mem_dump_d;
    logic        cap_m2r_q, cap_m2r_d;
    logic        cap_rw_q, cap_rw_d;
    logic        cap_dump_q, cap_dump_d;
    logic [2:0]  cap_wreg_q, cap_wreg_d;
    logic        wb_valid_q, wb_valid_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic [2:0]  wb_reg_q, wb_reg_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic        err_align_q, err_align_d;
    logic        halted_q, halted_d;
    logic        stall_c;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Value of the counter during the last WAIT cycle allowed before abort.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_timeout_q, err_timeout_d;
`endif

    // Next-state, capture and result logic for the IDLE/REQ/WAIT/RESP sequencer.
    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_rd_d      = 1'b0;
        mem_wr_d      = 1'b0;
        mem_dump_d    = 1'b0;
        cap_m2r_d     = cap_m2r_q;
        cap_rw_d      = cap_rw_q;
        cap_dump_d    = cap_dump_q;
        cap_wreg_d    = cap_wreg_q;
        wb_valid_d    = 1'b0;
        wb_data_d     = wb_data_q;
        wb_reg_d      = wb_reg_q;
        wb_regwrite_d = wb_regwrite_q;
        err_align_d   = 1'b0;
        halted_d      = halted_q;
        stall_c       = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        err_timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // A halted core ignores the pipeline entirely.
                if (in_valid && !halted_q) begin
                    if (!DMemEn_in) begin
                        wb_valid_d    = 1'b1;
                        wb_data_d     = aluOutput_in;
                        wb_reg_d      = WriteRegister_in;
                        wb_regwrite_d = RegWrite_in;
                    end else begin
                        stall_c     = 1'b1;
                        mem_addr_d  = aluOutput_in;
                        mem_wdata_d = B_in;
                        cap_m2r_d   = MemToReg_in;
                        cap_rw_d    = RegWrite_in;
                        cap_dump_d  = DMemDump_in;
                        cap_wreg_d  = WriteRegister_in;
                        if (aluOutput_in[0]) begin
                            // Odd address: skip memory, report alignment error. No read data exists.
                            state_d       = S_RESP;
                            wb_valid_d    = 1'b1;
                            wb_data_d     = MemToReg_in ? 16'h0000 : aluOutput_in;
                            wb_reg_d      = WriteRegister_in;
                            wb_regwrite_d = 1'b0;
                            err_align_d   = 1'b1;
                            halted_d      = halted_q | DMemDump_in;
                        end else begin
                            state_d    = S_REQ;
                            mem_rd_d   = !DMemWrite_in;
                            mem_wr_d   = DMemWrite_in;
                            mem_dump_d = DMemDump_in;
`ifdef MEM_ACCESS_TIMEOUT_EN
                            wait_cnt_d = '0;
`endif
                        end
                    end
                end
            end
            S_REQ, S_WAIT: begin
                stall_c = 1'b1;
                if (mem_done) begin
                    // Completion wins over a coincident timeout.
                    state_d       = S_RESP;
                    wb_valid_d    = 1'b1;
                    wb_data_d     = cap_m2r_q ? mem_rdata : mem_addr_q;
                    wb_reg_d      = cap_wreg_q;
                    wb_regwrite_d = cap_rw_q;
                    halted_d      = halted_q | cap_dump_q;
                end else begin
                    state_d = S_WAIT;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    if (state_q == S_WAIT) begin
                        if (wait_cnt_q == CNT_LAST) begin
                            state_d       = S_RESP;
                            wb_valid_d    = 1'b1;
                            wb_data_d     = 16'h0000;
                            wb_reg_d      = cap_wreg_q;
                            wb_regwrite_d = 1'b0;
                            err_timeout_d = 1'b1;
                            halted_d      = halted_q | cap_dump_q;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 1'b1;
                        end
                    end
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            mem_addr_q    <= 16'h0000;
            mem_wdata_q   <= 16'h0000;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_dump_q    <= 1'b0;
            cap_m2r_q     <= 1'b0;
            cap_rw_q      <= 1'b0;
            cap_dump_q    <= 1'b0;
            cap_wreg_q    <= 3'd0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= 16'h0000;
            wb_reg_q      <= 3'd0;
            wb_regwrite_q <= 1'b0;
            err_align_q   <= 1'b0;
            halted_q      <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wait_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            mem_dump_q    <= mem_dump_d;
            cap_m2r_q     <= cap_m2r_d;
            cap_rw_q      <= cap_rw_d;
            cap_dump_q    <= cap_dump_d;
            cap_wreg_q    <= cap_wreg_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_reg_q      <= wb_reg_d;
            wb_regwrite_q <= wb_regwrite_d;
            err_align_q   <= err_align_d;
            halted_q      <= halted_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

    // Stall is combinational so the accept cycle freezes upstream; reset forces it low.
    assign stall       = rst & stall_c;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_dump    = mem_dump_q;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_reg      = wb_reg_q;
    assign wb_regwrite = wb_regwrite_q;
    assign err_align   = err_align_q;
    assign halted      = halted_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: randomized ops, scoreboard queues of expected memory requests and writeback results.
// Expected values come from a transaction-level model: op kind, WAIT count and data give result cycle and contents.
// A negedge monitor pops and compares whenever the DUT strobes a request or a result.
module tb_mem_access_ctrl;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] aluOutput_in = 16'h0;
    logic [15:0] B_in = 16'h0;
    logic        DMemEn_in = 1'b0, DMemWrite_in = 1'b0, DMemDump_in = 1'b0;
    logic        MemToReg_in = 1'b0, RegWrite_in = 1'b0;
    logic [2:0]  WriteRegister_in = 3'd0;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_rd, mem_wr, mem_dump;
    logic        mem_done = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic        stall, wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  wb_reg;
    logic        wb_regwrite, err_align, err_timeout, halted;

    mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .aluOutput_in(aluOutput_in), .B_in(B_in),
        .DMemEn_in(DMemEn_in), .DMemWrite_in(DMemWrite_in), .DMemDump_in(DMemDump_in),
        .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in), .WriteRegister_in(WriteRegister_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_dump(mem_dump), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg),
        .wb_regwrite(wb_regwrite), .err_align(err_align), .err_timeout(err_timeout),
        .halted(halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [2:0]  rg;
        logic        rw;
        logic        ea;
        logic        et;
        logic        cd;
    } wb_exp_t;

    typedef struct {
        int          cyc;
        logic        rd;
        logic        wr;
        logic        dump;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_exp_t;

    wb_exp_t  wbq[$];
    req_exp_t reqq[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_en  = 1'b0;
    logic exp_stall = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle stall check, plus pop-and-compare on every request and result strobe.
    always @(negedge clk) begin : monitor
        wb_exp_t  w;
        req_exp_t r;
        if (rst && chk_en) begin
            chk("stall", 64'(stall), 64'(exp_stall));
            if (!wb_valid) chk("err_without_wb", 64'({err_align, err_timeout}), 64'(0));
            if (mem_rd || mem_wr || mem_dump) begin
                if (reqq.size() == 0) chk("unexpected_req", 64'(1), 64'(0));
                else begin
                    r = reqq.pop_front();
                    chk("req_cycle", 64'(cyc), 64'(r.cyc));
                    chk("req_strobes", 64'({mem_rd, mem_wr, mem_dump}), 64'({r.rd, r.wr, r.dump}));
                    chk("req_addr", 64'(mem_addr), 64'(r.addr));
                    chk("req_wdata", 64'(mem_wdata), 64'(r.wdata));
                end
            end
            if (wb_valid) begin
                if (wbq.size() == 0) chk("unexpected_wb", 64'(1), 64'(0));
                else begin
                    w = wbq.pop_front();
                    chk("wb_cycle", 64'(cyc), 64'(w.cyc));
                    if (w.cd) chk("wb_data", 64'(wb_data), 64'(w.data));
                    chk("wb_reg", 64'(wb_reg), 64'(w.rg));
                    chk("wb_regwrite", 64'(wb_regwrite), 64'(w.rw));
                    chk("err_align", 64'(err_align), 64'(w.ea));
                    chk("err_timeout", 64'(err_timeout), 64'(w.et));
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid     = 1'b0;
            DMemEn_in    = 1'($urandom);
            aluOutput_in = 16'($urandom);
            mem_done     = 1'($urandom);
            mem_rdata    = 16'($urandom);
            exp_stall    = 1'b0;
            tick();
        end
    endtask

    task automatic do_alu(input logic [15:0] a, input logic [2:0] rg, input logic rw);
        wb_exp_t w;
        in_valid = 1'b1; DMemEn_in = 1'b0; aluOutput_in = a; WriteRegister_in = rg;
        RegWrite_in = rw; DMemWrite_in = 1'($urandom); DMemDump_in = 1'($urandom);
        MemToReg_in = 1'($urandom); B_in = 16'($urandom);
        mem_done = 1'($urandom); mem_rdata = 16'($urandom);
        exp_stall = 1'b0;
        w.cyc = cyc + 1; w.data = a; w.rg = rg; w.rw = rw; w.ea = 1'b0; w.et = 1'b0; w.cd = 1'b1;
        wbq.push_back(w);
        tick();
        in_valid = 1'b0;
    endtask

    // d = number of WAIT cycles before mem_done (0: done during REQ); d < 0: memory never answers.
    task automatic do_mem(input logic [15:0] addr, input logic [15:0] wdata, input logic [15:0] rdata,
                          input logic wr, input logic m2r, input logic rw, input logic dump,
                          input logic [2:0] rg, input int d);
        wb_exp_t  w;
        req_exp_t r;
        int       c;
        int       n;
        c = cyc;
        in_valid = 1'b1; DMemEn_in = 1'b1; aluOutput_in = addr; B_in = wdata;
        DMemWrite_in = wr; DMemDump_in = dump; MemToReg_in = m2r; RegWrite_in = rw;
        WriteRegister_in = rg; mem_done = 1'($urandom); mem_rdata = 16'($urandom);
        exp_stall = 1'b1;
        w.rg = rg; w.ea = 1'b0; w.et = 1'b0; w.cd = 1'b1;
        if (addr[0]) begin
            w.cyc = c + 1; w.data = 16'h0; w.rw = 1'b0; w.ea = 1'b1; w.cd = 1'b0;
            wbq.push_back(w);
            tick();
        end else begin
            r.cyc = c + 1; r.rd = ~wr; r.wr = wr; r.dump = dump; r.addr = addr; r.wdata = wdata;
            reqq.push_back(r);
            n = (d < 0) ? T : d;
            w.cyc  = c + 2 + n;
            w.data = (d < 0) ? 16'h0000 : (m2r ? rdata : addr);
            w.rw   = (d < 0) ? 1'b0 : rw;
            w.et   = (d < 0);
            wbq.push_back(w);
            for (int j = 0; j <= n; j++) begin
                tick();
                mem_done  = (j == d);
                mem_rdata = (j == d) ? rdata : 16'($urandom);
            end
            tick();
        end
        exp_stall = 1'b0;
        in_valid  = 1'b0;
        mem_done  = 1'($urandom);
        tick();
    endtask

    task automatic rand_op();
        int          k;
        logic [15:0] a;
        k = $urandom_range(0, 9);
        a = 16'($urandom);
        if (k < 4) do_alu(a, 3'($urandom), 1'($urandom));
        else if (k < 5) do_mem(a | 16'h1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                               1'($urandom), 1'b0, 3'($urandom), 0);
        else do_mem(a & 16'hFFFE, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'b0, 3'($urandom), $urandom_range(0, 4));
    endtask

    initial begin : stimulus
        // Reset held with a live memory op presented: every output must stay 0.
        in_valid = 1'b1; DMemEn_in = 1'b1; aluOutput_in = 16'h0040; mem_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs",
                64'({mem_addr, mem_wdata, mem_rd, mem_wr, mem_dump, stall, wb_valid, wb_data,
                     wb_reg, wb_regwrite, err_align, err_timeout, halted}), 64'(0));
        end
        tick();
        rst = 1'b1; in_valid = 1'b0; mem_done = 1'b0; exp_stall = 1'b0; chk_en = 1'b1;
        idle(2);

        do_alu(16'h1234, 3'd5, 1'b1);
        idle(1);
        do_mem(16'h0040, 16'h5555, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 3);
        do_mem(16'h0010, 16'h00AA, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1);
        do_mem(16'h0011, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 0);
        do_mem(16'h0022, 16'h0000, 16'h7777, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 0);
        do_alu(16'hFFFF, 3'd7, 1'b1);
        do_alu(16'h0001, 3'd1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            rand_op();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // Reset asserted in the second WAIT cycle of a load.
        begin
            req_exp_t r;
            r.cyc = cyc + 1; r.rd = 1'b1; r.wr = 1'b0; r.dump = 1'b0; r.addr = 16'h0A42; r.wdata = 16'h0123;
            reqq.push_back(r);
            in_valid = 1'b1; DMemEn_in = 1'b1; DMemWrite_in = 1'b0; DMemDump_in = 1'b0;
            MemToReg_in = 1'b1; RegWrite_in = 1'b1; aluOutput_in = 16'h0A42; B_in = 16'h0123;
            exp_stall = 1'b1; mem_done = 1'b0;
            tick(); tick(); tick();
            chk_en = 1'b0; rst = 1'b0;
            #1;
            chk("rst_async_stall", 64'(stall), 64'(0));
            chk("rst_async_strobes_wb", 64'({mem_rd, mem_wr, mem_dump, wb_valid}), 64'(0));
            chk("rst_async_addr", 64'(mem_addr), 64'(0));
            @(negedge clk);
            tick();
            rst = 1'b1; in_valid = 1'b0; exp_stall = 1'b0; chk_en = 1'b1;
            do_alu(16'h4321, 3'd6, 1'b1);
        end

`ifdef MEM_ACCESS_TIMEOUT_EN
        do_mem(16'h0100, 16'h0000, 16'hAAAA, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, -1);
        do_mem(16'h0102, 16'h0000, 16'hC0DE, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, T);
`else
        do_mem(16'h0100, 16'h0000, 16'hAAAA, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 12);
`endif

        // Dump completes; afterwards the controller must ignore all inputs.
        do_mem(16'h0200, 16'h0000, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1);
        idle(3);
        chk("halted_set", 64'(halted), 64'(1));
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; DMemEn_in = 1'(i % 2); aluOutput_in = 16'($urandom) & 16'hFFFE;
            RegWrite_in = 1'b1; mem_done = 1'($urandom); exp_stall = 1'b0;
            tick();
        end
        idle(2);
        chk("halted_sticky", 64'(halted), 64'(1));

        chk("wb_queue_drained", 64'(wbq.size()), 64'(0));
        chk("req_queue_drained", 64'(reqq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
